ofdm_sync_ctrl: RTL and testbench
=================================

# ofdm_sync_ctrl

Controller that sequences the Schmidl-Cox OFDM frame-sync datapath. It arms the detector and accepts one plateau trigger per frame. It forwards the latched coarse phase offset to the phase accumulator, then waits for end-of-frame from the periodic framer. It enforces a hold-off and a frame timeout, and flushes the datapath with `det_clear` on timeout or disable. It sits between the plateau detector/trigger split, the phase accumulator, the framer and the settings bus.

## Interface
- `SR_CTRL`, 6: settings address. bit0 = enable, bit1 = one_shot.
- `SR_TIMEOUT`, 7: settings address. [WIDTH_CNT-1:0] = frame timeout in cycles; 0 disables the timeout.
- `SR_HOLDOFF`, 8: settings address. [WIDTH_CNT-1:0] = post-frame hold-off in cycles.
- `WIDTH_CNT`, 16: width of the timeout, hold-off and status counters.
- `FLUSH_CYCLES`, 8: number of cycles `det_clear` is held high (≥1).
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high. Clears all state, registers and counters.
- `clear` in 1: synchronous. Forces IDLE, zeroes the counters, keeps settings, drops any pending phase.
- `set_stb` in 1, `set_addr` in 8, `set_data` in 32: settings bus. A write takes effect the cycle after the strobe.
- `trig_tdata` in 16: phase offset at trigger. `trig_tvalid` in 1. `trig_tready` out 1.
- `eof` in 1: single-cycle pulse from the framer.
- `phase_tdata` out 16, `phase_tvalid` out 1, `phase_tready` in 1: phase offset to the accumulator.
- `det_enable` out 1: arms the detector datapath.
- `det_clear` out 1: flush pulse to the datapath `clear` inputs.
- `state_o` out 3: current state encoding.
- `frame_count` out WIDTH_CNT, `timeout_count` out WIDTH_CNT, `drop_count` out WIDTH_CNT: status counters.

## Operation
- States and encodings: IDLE=0, SEARCH=1, FRAME=2, HOLDOFF=3, FLUSH=4.
- IDLE:
  - `det_enable`=0, `trig_tready`=1; triggers are discarded and not counted.
  - Goes to SEARCH when enable=1.
- SEARCH:
  - `det_enable`=1, `trig_tready` = !`phase_tvalid`.
  - On a trigger handshake: latch `trig_tdata` into the phase register, set `phase_tvalid`, load the timeout counter, go to FRAME.
- FRAME:
  - `trig_tready`=1; each accepted trigger increments `drop_count`.
  - On `eof`: increment `frame_count`, load the hold-off counter, go to HOLDOFF.
  - If one_shot=1, `eof` instead clears the enable bit and goes to IDLE.
  - If timeout≠0 and the counter expires with no `eof`: increment `timeout_count` and go to FLUSH.
- HOLDOFF:
  - Triggers are dropped and counted.
  - Returns to SEARCH when the counter reaches 0. A hold-off of 0 gives exactly 1 cycle in HOLDOFF.
- FLUSH:
  - `det_clear`=1 for FLUSH_CYCLES cycles and `det_enable`=0.
  - Also clears `phase_tvalid` if it is still pending.
  - Then goes to SEARCH if enable=1, otherwise IDLE.
- Enable written to 0 in SEARCH, FRAME or HOLDOFF goes to FLUSH.
- `phase_tvalid` is held with stable data until `phase_tready`, independent of state. It is cleared only by the handshake, FLUSH, `clear` or `reset`.
- Counters saturate at all-ones and do not wrap.
- Simultaneous events, by priority:
  - `reset` > `clear` > disable > `eof` > timeout.
  - `eof` on the cycle the timeout expires counts as a frame, not a timeout.
  - `eof` outside FRAME is ignored.
  - A trigger in the same cycle SEARCH is entered is accepted.

## Timing
- Reset values:
  - `det_enable`=0, `det_clear`=0, `trig_tready`=1, `phase_tvalid`=0, `phase_tdata`=0.
  - `state_o`=0 and all counters 0.
  - Settings: enable=0, one_shot=0, timeout=0, hold-off=0.
- All outputs are registered except `trig_tready`, which is combinational from state and `phase_tvalid`.
- Trigger handshake at cycle N: `phase_tvalid`=1 and `state_o`=2 at N+1.
- Enable write strobe at N: register=1 at N+1, `state_o`=1 and `det_enable`=1 at N+2.
- Timeout T: counter loaded at the handshake; FLUSH entered T+1 cycles after the handshake cycle.
- FLUSH: `det_clear` high exactly FLUSH_CYCLES consecutive cycles; next state on the following cycle.
- Hold-off H: SEARCH re-entered H+1 cycles after the `eof` cycle.
- `reset` asserted mid-frame: all outputs take their reset values asynchronously, with no `det_clear` pulse.

## Configuration
- `OFDM_SYNC_CTRL_STATUS_EN` defined: `frame_count`, `timeout_count` and `drop_count` are implemented as specified.
- Not defined: no counter logic is built; the three status outputs are tied to 0. The state machine and `state_o` are unchanged.

## Test plan
- Basic frame: enable=1, timeout=0, hold-off=4; trigger 0x1234; `phase_tready` high; `eof` 200 cycles later.
  - Expect `phase_tdata`=0x1234 for 1 cycle, `frame_count`=1, SEARCH 5 cycles after `eof`.
- Timeout: timeout=100, trigger, no `eof`.
  - Expect FLUSH 101 cycles after the handshake, `det_clear` high 8 cycles, `timeout_count`=1, back to SEARCH.
- Back-pressure and drops: `phase_tready`=0 for 50 cycles after a trigger; 3 more triggers during FRAME.
  - Expect `phase_tdata` stable throughout, `drop_count`=3, one phase transfer when ready rises.
- Simultaneous: `eof` on the exact timeout-expiry cycle.
  - Expect `frame_count`=1, `timeout_count`=0, state HOLDOFF.
- One-shot and disable:
  - one_shot=1: after `eof`, IDLE with the enable bit read back 0.
  - Separately, enable→0 in FRAME: FLUSH, then IDLE, with `det_enable`=0.
- Reset mid-FRAME with `phase_tvalid` pending.
  - Expect all outputs at reset values in the same cycle and `clear` semantics untouched.
  - Repeat with the macro undefined: counters read 0.

Source files
------------

// File: rtl/ofdm_sync_ctrl_if.sv
// Valid/ready stream bundle used for the trigger input and the phase output of ofdm_sync_ctrl.
interface ofdm_sync_ctrl_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/ofdm_sync_ctrl.sv
// Schmidl-Cox frame-sync sequencer: arms the detector, forwards the trigger phase, enforces hold-off/timeout.
// Define OFDM_SYNC_CTRL_STATUS_EN to build the frame/timeout/drop status counters; otherwise they read 0.
module ofdm_sync_ctrl #(
    parameter logic [7:0]  SR_CTRL      = 8'd6,
    parameter logic [7:0]  SR_TIMEOUT   = 8'd7,
    parameter logic [7:0]  SR_HOLDOFF   = 8'd8,
    parameter int unsigned WIDTH_CNT    = 16,
    parameter int unsigned FLUSH_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 set_stb,
    input  logic [7:0]           set_addr,
    input  logic [31:0]          set_data,
    ofdm_sync_ctrl_if.slave      trig,
    input  logic                 eof,
    ofdm_sync_ctrl_if.master     phase,
    output logic                 det_enable,
    output logic                 det_clear,
    output logic [2:0]           state_o,
    output logic [WIDTH_CNT-1:0] frame_count,
    output logic [WIDTH_CNT-1:0] timeout_count,
    output logic [WIDTH_CNT-1:0] drop_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEARCH  = 3'd1,
        FRAME   = 3'd2,
        HOLDOFF = 3'd3,
        FLUSH   = 3'd4
    } state_t;

    state_t               state, state_n;
    logic                 enable_r, one_shot_r;
    logic [WIDTH_CNT-1:0] timeout_r, holdoff_r, cnt;
    logic                 cnt_last, cnt_expire;
    logic                 trig_hs, trig_latch, oneshot_stop;
    logic [15:0]          phase_data_r;
    logic                 phase_valid_r;
    logic                 unused_set_bits;

    assign unused_set_bits = &set_data[31:WIDTH_CNT];
    assign cnt_last        = (cnt == '0) || (cnt == WIDTH_CNT'(1));
    assign cnt_expire      = (cnt == WIDTH_CNT'(1));
    assign trig.tready     = (state == SEARCH) ? !phase_valid_r : 1'b1;
    assign trig_hs         = trig.tvalid && trig.tready;
    assign phase.tdata     = phase_data_r;
    assign phase.tvalid    = phase_valid_r;
    assign state_o         = state;

    // One-shot clear is applied after the bus write so the frame end wins a same-cycle write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_r   <= 1'b0;
            one_shot_r <= 1'b0;
            timeout_r  <= '0;
            holdoff_r  <= '0;
        end else begin
            if (set_stb && set_addr == SR_CTRL) begin
                enable_r   <= set_data[0];
                one_shot_r <= set_data[1];
            end
            if (set_stb && set_addr == SR_TIMEOUT)
                timeout_r <= set_data[WIDTH_CNT-1:0];
            if (set_stb && set_addr == SR_HOLDOFF)
                holdoff_r <= set_data[WIDTH_CNT-1:0];
            if (oneshot_stop)
                enable_r <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n      = state;
        trig_latch   = 1'b0;
        oneshot_stop = 1'b0;
        if (clear) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (enable_r) state_n = SEARCH;
                SEARCH: begin
                    if (!enable_r) begin
                        state_n = FLUSH;
                    end else if (trig_hs) begin
                        state_n    = FRAME;
                        trig_latch = 1'b1;
                    end
                end
                FRAME: begin
                    if (!enable_r) begin
                        state_n = FLUSH;
                    end else if (eof) begin
                        if (one_shot_r) begin
                            state_n      = IDLE;
                            oneshot_stop = 1'b1;
                        end else begin
                            state_n = HOLDOFF;
                        end
                    end else if (cnt_expire) begin
                        state_n = FLUSH;
                    end
                end
                HOLDOFF: begin
                    if (!enable_r)     state_n = FLUSH;
                    else if (cnt_last) state_n = SEARCH;
                end
                FLUSH: if (cnt_last) state_n = enable_r ? SEARCH : IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // Shared down-counter: reloaded on entry to each timed state, a zero load never expires in FRAME.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (state_n == FRAME && state != FRAME) begin
            cnt <= timeout_r;
        end else if (state_n == HOLDOFF && state != HOLDOFF) begin
            cnt <= holdoff_r;
        end else if (state_n == FLUSH && state != FLUSH) begin
            cnt <= WIDTH_CNT'(FLUSH_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - WIDTH_CNT'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            det_enable <= 1'b0;
            det_clear  <= 1'b0;
        end else begin
            det_enable <= (state_n == SEARCH) || (state_n == FRAME) || (state_n == HOLDOFF);
            det_clear  <= (state_n == FLUSH);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_valid_r <= 1'b0;
            phase_data_r  <= '0;
        end else if (clear || state_n == FLUSH) begin
            phase_valid_r <= 1'b0;
        end else if (trig_latch) begin
            phase_data_r  <= trig.tdata;
            phase_valid_r <= 1'b1;
        end else if (phase.tready) begin
            phase_valid_r <= 1'b0;
        end
    end

`ifdef OFDM_SYNC_CTRL_STATUS_EN
    logic                 frame_inc, timeout_inc, drop_inc;
    logic [WIDTH_CNT-1:0] frame_cnt_r, timeout_cnt_r, drop_cnt_r;

    assign frame_inc   = !clear && enable_r && state == FRAME && eof;
    assign timeout_inc = !clear && enable_r && state == FRAME && !eof && state_n == FLUSH;
    assign drop_inc    = !clear && trig_hs && (state == FRAME || state == HOLDOFF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_r   <= '0;
            timeout_cnt_r <= '0;
            drop_cnt_r    <= '0;
        end else if (clear) begin
            frame_cnt_r   <= '0;
            timeout_cnt_r <= '0;
            drop_cnt_r    <= '0;
        end else begin
            if (frame_inc && frame_cnt_r != '1)     frame_cnt_r   <= frame_cnt_r + WIDTH_CNT'(1);
            if (timeout_inc && timeout_cnt_r != '1) timeout_cnt_r <= timeout_cnt_r + WIDTH_CNT'(1);
            if (drop_inc && drop_cnt_r != '1)       drop_cnt_r    <= drop_cnt_r + WIDTH_CNT'(1);
        end
    end

    assign frame_count   = frame_cnt_r;
    assign timeout_count = timeout_cnt_r;
    assign drop_count    = drop_cnt_r;
`else
    assign frame_count   = '0;
    assign timeout_count = '0;
    assign drop_count    = '0;
`endif

endmodule

// File: tb/tb_ofdm_sync_ctrl.sv
// Scoreboard bench for ofdm_sync_ctrl: directed test-plan scenarios followed by randomized traffic.
module tb_ofdm_sync_ctrl;
    localparam int unsigned FLUSH = 8;
    localparam logic [7:0]  A_CTRL = 8'd6;
    localparam logic [7:0]  A_TO   = 8'd7;
    localparam logic [7:0]  A_HO   = 8'd8;

    logic        clk = 1'b0, reset = 1'b0, clear = 1'b0, set_stb = 1'b0, eof = 1'b0;
    logic [7:0]  set_addr = '0;
    logic [31:0] set_data = '0;
    logic        det_enable, det_clear;
    logic [2:0]  state_o;
    logic [15:0] frame_count, timeout_count, drop_count;

    ofdm_sync_ctrl_if #(.WIDTH(16)) trig_if ();
    ofdm_sync_ctrl_if #(.WIDTH(16)) phase_if ();

    ofdm_sync_ctrl #(
        .SR_CTRL(A_CTRL), .SR_TIMEOUT(A_TO), .SR_HOLDOFF(A_HO),
        .WIDTH_CNT(16), .FLUSH_CYCLES(FLUSH)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .trig(trig_if.slave), .eof(eof), .phase(phase_if.master),
        .det_enable(det_enable), .det_clear(det_clear), .state_o(state_o),
        .frame_count(frame_count), .timeout_count(timeout_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic int cnt_exp(input int v);
`ifdef OFDM_SYNC_CTRL_STATUS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    // Reference model: states 0..4, timed states tracked as absolute exit edge numbers.
    typedef struct {
        int          st;
        bit          pv;
        logic [15:0] pd;
        int          fc, tc, dc;
    } snap_t;

    snap_t       snap_q[$];
    logic [15:0] ph_q[$];

    int          m_st, m_fc, m_tc, m_dc, m_to, m_ho, m_dl, m_cyc, nst;
    bit          m_en, m_os, m_pv, m_latch, rdy, hs, stop;
    logic [15:0] m_pd;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_st = 0; m_pv = 0; m_pd = '0; m_fc = 0; m_tc = 0; m_dc = 0;
            m_en = 0; m_os = 0; m_to = 0; m_ho = 0; m_dl = -1; m_latch = 0;
            snap_q.delete();
            ph_q.delete();
        end else begin
            rdy     = (m_st == 1) ? !m_pv : 1'b1;
            hs      = trig_if.tvalid && rdy;
            m_latch = 0;
            stop    = 0;
            nst     = m_st;
            if (m_pv && phase_if.tready) m_pv = 0;
            if (clear) begin
                nst = 0; m_fc = 0; m_tc = 0; m_dc = 0;
                if (m_pv) begin m_pv = 0; void'(ph_q.pop_back()); end
            end else begin
                case (m_st)
                    0: if (m_en) nst = 1;
                    1: begin
                        if (!m_en) nst = 4;
                        else if (hs) begin
                            nst = 2; m_pv = 1; m_pd = trig_if.tdata; m_latch = 1;
                            ph_q.push_back(trig_if.tdata);
                            m_dl = (m_to == 0) ? -1 : m_cyc + m_to;
                        end
                    end
                    2: begin
                        if (hs) m_dc = sat(m_dc);
                        if (!m_en) nst = 4;
                        else if (eof) begin
                            m_fc = sat(m_fc);
                            if (m_os) begin nst = 0; stop = 1; end
                            else begin nst = 3; m_dl = m_cyc + ((m_ho == 0) ? 1 : m_ho); end
                        end else if (m_dl == m_cyc) begin
                            m_tc = sat(m_tc); nst = 4;
                        end
                    end
                    3: begin
                        if (hs) m_dc = sat(m_dc);
                        if (!m_en) nst = 4;
                        else if (m_cyc == m_dl) nst = 1;
                    end
                    default: if (m_cyc == m_dl) nst = m_en ? 1 : 0;
                endcase
                if (nst == 4 && m_st != 4) begin
                    m_dl = m_cyc + FLUSH;
                    if (m_pv) begin m_pv = 0; void'(ph_q.pop_back()); end
                end
            end
            m_st = nst;
            if (set_stb) begin
                if (set_addr == A_CTRL) begin m_en = set_data[0]; m_os = set_data[1]; end
                if (set_addr == A_TO) m_to = int'(set_data[15:0]);
                if (set_addr == A_HO) m_ho = int'(set_data[15:0]);
            end
            if (stop) m_en = 0;
            m_cyc++;
        end
        snap_q.push_back('{m_st, m_pv, m_pd, m_fc, m_tc, m_dc});
    end

    snap_t cur;
    always @(negedge clk) begin
        if (snap_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard: no expected entry at %0t", $time);
        end else begin
            cur = snap_q.pop_front();
            chk("state_o", 32'(state_o), 32'(cur.st));
            chk("det_enable", 32'(det_enable), 32'(cur.st >= 1 && cur.st <= 3));
            chk("det_clear", 32'(det_clear), 32'(cur.st == 4));
            chk("phase_tvalid", 32'(phase_if.tvalid), 32'(cur.pv));
            chk("phase_tdata", 32'(phase_if.tdata), 32'(cur.pd));
            chk("trig_tready", 32'(trig_if.tready), 32'((cur.st == 1) ? !cur.pv : 1'b1));
            chk("frame_count", 32'(frame_count), 32'(cnt_exp(cur.fc)));
            chk("timeout_count", 32'(timeout_count), 32'(cnt_exp(cur.tc)));
            chk("drop_count", 32'(drop_count), 32'(cnt_exp(cur.dc)));
        end
        if (phase_if.tvalid && phase_if.tready && !reset) begin
            if (ph_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL phase_xfer: transfer of %0h with none expected", phase_if.tdata);
            end else begin
                chk("phase_xfer", 32'(phase_if.tdata), 32'(ph_q.pop_front()));
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic write(input logic [7:0] addr, input logic [31:0] data);
        set_stb = 1'b1; set_addr = addr; set_data = data;
        cycle();
        set_stb = 1'b0;
    endtask

    task automatic wait_state(input int s, input int max);
        int n = 0;
        while (m_st != s && n < max) begin cycle(); n++; end
        if (m_st != s) begin
            checks++; errors++;
            $display("FAIL wait_state: state %0d required %0d", m_st, s);
        end
    endtask

    task automatic trigger(input logic [15:0] d);
        int n = 0;
        trig_if.tvalid = 1'b1; trig_if.tdata = d;
        do begin cycle(); n++; end while (!m_latch && n < 60);
        trig_if.tvalid = 1'b0;
        if (!m_latch) begin
            checks++; errors++;
            $display("FAIL trigger: latched %0d required 1", m_latch);
        end
    endtask

    task automatic pulse_eof();
        eof = 1'b1; cycle(); eof = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_det_enable", 32'(det_enable), 0);
        chk("rst_det_clear", 32'(det_clear), 0);
        chk("rst_trig_tready", 32'(trig_if.tready), 1);
        chk("rst_phase_tvalid", 32'(phase_if.tvalid), 0);
        chk("rst_phase_tdata", 32'(phase_if.tdata), 0);
        chk("rst_state_o", 32'(state_o), 0);
        chk("rst_frame_count", 32'(frame_count), 0);
        chk("rst_timeout_count", 32'(timeout_count), 0);
        chk("rst_drop_count", 32'(drop_count), 0);
    endtask

    initial begin
        int r;
        trig_if.tvalid = 1'b0; trig_if.tdata = '0; phase_if.tready = 1'b1;
        #1 reset = 1'b1;
        #1 check_reset_outputs();
        repeat (3) cycle();
        reset = 1'b0;
        cycle();

        // basic frame
        write(A_HO, 4); write(A_TO, 0); write(A_CTRL, 1);
        wait_state(1, 10);
        trigger(16'h1234);
        repeat (199) cycle();
        pulse_eof();
        wait_state(1, 20);

        // timeout
        write(A_TO, 100);
        trigger(16'h0badd);
        wait_state(4, 120);
        wait_state(1, 20);

        // back-pressure and drops
        write(A_TO, 0);
        phase_if.tready = 1'b0;
        trigger(16'hbeef);
        repeat (3) begin
            repeat (10) cycle();
            trig_if.tvalid = 1'b1; trig_if.tdata = 16'h5555; cycle(); trig_if.tvalid = 1'b0;
        end
        repeat (17) cycle();
        phase_if.tready = 1'b1;
        repeat (5) cycle();
        pulse_eof();
        wait_state(1, 20);

        // eof on the timeout-expiry cycle
        write(A_TO, 20);
        trigger(16'h2020);
        repeat (19) cycle();
        pulse_eof();
        wait_state(1, 20);

        // one-shot
        write(A_TO, 0); write(A_CTRL, 3);
        wait_state(1, 10);
        trigger(16'h0001);
        repeat (10) cycle();
        pulse_eof();
        repeat (10) cycle();

        // disable during FRAME
        write(A_CTRL, 1);
        wait_state(1, 10);
        trigger(16'h0002);
        repeat (5) cycle();
        write(A_CTRL, 0);
        wait_state(0, 30);
        repeat (3) cycle();

        // asynchronous reset mid-frame with the phase still pending
        write(A_CTRL, 1);
        wait_state(1, 10);
        phase_if.tready = 1'b0;
        trigger(16'h7777);
        repeat (3) cycle();
        reset = 1'b1;
        #1 check_reset_outputs();
        cycle(); cycle();
        reset = 1'b0;
        phase_if.tready = 1'b1;
        cycle();

        // synchronous clear mid-frame
        write(A_HO, 2); write(A_CTRL, 1);
        wait_state(1, 10);
        phase_if.tready = 1'b0;
        trigger(16'h4242);
        repeat (4) cycle();
        clear = 1'b1; cycle(); clear = 1'b0;
        phase_if.tready = 1'b1;
        repeat (5) cycle();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            trig_if.tvalid  = ($urandom_range(7) == 0);
            trig_if.tdata   = 16'($urandom);
            phase_if.tready = ($urandom_range(3) != 0);
            eof             = ($urandom_range(39) == 0);
            clear           = ($urandom_range(599) == 0);
            set_stb         = 1'b0;
            if ($urandom_range(49) == 0) begin
                set_stb = 1'b1;
                r = int'($urandom_range(9));
                case ($urandom_range(2))
                    0: begin set_addr = A_CTRL; set_data = (r == 0) ? 32'd3 : (r == 1) ? 32'd0 : 32'd1; end
                    1: begin set_addr = A_TO; set_data = 32'($urandom_range(60)); end
                    default: begin set_addr = A_HO; set_data = 32'($urandom_range(10)); end
                endcase
            end
            cycle();
        end
        trig_if.tvalid = 1'b0; eof = 1'b0; clear = 1'b0; set_stb = 1'b0; phase_if.tready = 1'b1;
        repeat (5) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
